// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the fetch/decode/execute/writeback sequencer.
// Optional JAL support is selected with the SEQ_JAL_EN macro.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    K_ALU,
    K_LOAD,
    K_STOR,
    K_BR,
    K_JAL,
    K_ILL
  } kind_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LS    = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_LUI   = 4'hF;

  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_SHREG = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_LO = 4'hC;
  localparam logic [3:0] CC_HS = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;

  localparam int PSR_N = 4;
  localparam int PSR_Z = 3;
  localparam int PSR_F = 2;
  localparam int PSR_L = 1;

  function automatic logic is_imm_op(input logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h3, 4'h5,
                      4'h6, 4'h9, 4'hB, 4'hD};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/ctrl_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code
// and the current flags to a taken decision.
module ctrl_cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic unused_flags;
  assign unused_flags = ^{flags[PSR_F], flags[0]};

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = flags[PSR_Z];
      CC_NE:   taken = !flags[PSR_Z];
      CC_GT:   taken = flags[PSR_N];
      CC_LE:   taken = !flags[PSR_N];
      CC_LO:   taken = flags[PSR_L];
      CC_HS:   taken = !flags[PSR_L];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller.
// Define SEQ_JAL_EN to enable the JAL instruction (op=0100 ext=1000).
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [15:0]       dmem_rdata,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  input  logic [15:0]       rf_rdata_a,
  input  logic [15:0]       rf_rdata_b,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic [7:0]        alu_opcode,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  input  logic [4:0]        alu_psr,
  output logic              retire,
  output logic              illegal_op,
  output logic [ADDR_W-1:0] pc
);

  state_t            state;
  kind_t             kind;
  logic [15:0]       ir;
  logic [4:0]        flags;
  logic              wr;
  logic [ADDR_W-1:0] npc;
  logic [15:0]       mdr;

  logic [3:0] op, rd, ext, rs;
  logic [7:0] imm;
  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign ext = ir[7:4];
  assign rs  = ir[3:0];
  assign imm = ir[7:0];

  logic [ADDR_W-1:0] pc_inc, br_off;
  assign pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign br_off = {{(ADDR_W-8){imm[7]}}, imm};

  logic taken;
  ctrl_cond_eval u_cond (
    .cond  (rd),
    .flags (flags),
    .taken (taken)
  );

  kind_t             d_kind;
  logic              d_wr;
  logic [7:0]        d_opc;
  logic [15:0]       d_b;
  logic [ADDR_W-1:0] d_npc;

  always_comb begin
    d_kind = K_ILL;
    d_wr   = 1'b0;
    d_opc  = 8'h00;
    d_b    = 16'h0000;
    d_npc  = pc_inc;
    unique case (1'b1)
      op == OP_RTYPE: begin
        d_kind = K_ALU;
        d_opc  = {4'h0, ext};
        d_b    = rf_rdata_b;
        d_wr   = ext != EXT_CMP;
      end
      is_imm_op(op): begin
        d_kind = K_ALU;
        d_opc  = {4'h0, op};
        d_b    = sext8(imm);
        d_wr   = op != OP_CMP;
      end
      op == OP_LUI: begin
        d_kind = K_ALU;
        d_opc  = 8'hF0;
        d_b    = {8'h00, imm};
        d_wr   = 1'b1;
      end
      op == OP_SHIFT: begin
        d_kind = K_ALU;
        d_opc  = {OP_SHIFT, ext};
        d_b    = (ext == EXT_SHREG) ?
                 rf_rdata_b : {12'h000, rs};
        d_wr   = 1'b1;
      end
      op == OP_BCOND: begin
        d_kind = K_BR;
        if (taken)
          d_npc = pc + br_off;
      end
      op == OP_LS: begin
        case (ext)
          EXT_LOAD: begin
            d_kind = K_LOAD;
            d_wr   = 1'b1;
          end
          EXT_STOR: d_kind = K_STOR;
          EXT_JCOND: begin
            d_kind = K_BR;
            if (taken)
              d_npc = rf_rdata_b[ADDR_W-1:0];
          end
`ifdef SEQ_JAL_EN
          EXT_JAL: begin
            d_kind = K_JAL;
            d_wr   = 1'b1;
            d_npc  = rf_rdata_b[ADDR_W-1:0];
          end
`endif
          default: d_kind = K_ILL;
        endcase
      end
      default: d_kind = K_ILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      npc        <= RESET_PC;
      ir         <= '0;
      flags      <= '0;
      kind       <= K_ILL;
      wr         <= 1'b0;
      mdr        <= '0;
      imem_req   <= 1'b0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_req && imem_valid) begin
            ir         <= imem_rdata;
            rf_raddr_a <= imem_rdata[11:8];
            rf_raddr_b <= imem_rdata[3:0];
            imem_req   <= 1'b0;
            state      <= S_DECODE;
          end else begin
            imem_req <= run;
          end
        end
        S_DECODE: begin
          kind <= d_kind;
          wr   <= d_wr;
          npc  <= d_npc;
          mdr  <= 16'(pc_inc);
          alu_opcode <= d_opc;
          alu_a <= (d_kind == K_ALU) ? rf_rdata_a : '0;
          alu_b <= d_b;
          if (d_kind == K_LOAD || d_kind == K_STOR) begin
            dmem_req   <= 1'b1;
            dmem_we    <= d_kind == K_STOR;
            dmem_addr  <= rf_rdata_b[ADDR_W-1:0];
            dmem_wdata <= (d_kind == K_STOR) ? rf_rdata_a : '0;
            state      <= S_MEM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_MEM: begin
          // Request stays frozen until the memory completes it.
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            mdr      <= dmem_rdata;
            state    <= S_WB;
          end
        end
        S_WB: begin
          pc <= npc;
          if (kind == K_ALU)
            flags <= alu_psr;
          imem_req <= run;
          state    <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  logic in_wb;
  assign in_wb = state == S_WB;

  // Writeback strobes are decoded from state so the ALU result
  // arriving in WB can be written the same cycle.
  assign imem_addr  = pc;
  assign retire     = in_wb;
  assign illegal_op = in_wb && kind == K_ILL;
  assign rf_we      = in_wb && wr;
  assign rf_waddr   = rf_we ? rd : 4'h0;
  assign rf_wdata   = !rf_we ? 16'h0000 :
                      (kind == K_ALU) ? alu_result : mdr;

endmodule
